sr_ff: RTL and testbench



---
 rtl/sr_ff.sv | 93 +++++++++
 tb/tb_sr_ff.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sr_ff.sv
// sr_ff: bank of WIDTH independent clocked SR flip-flops, async active-low reset.
// Defining SRFF_CONFLICT_FLAG_EN adds the registered conflict / conflict_seen outputs.
module sr_ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      BOTH_MODE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
`ifdef SRFF_CONFLICT_FLAG_EN
    ,
    output logic [WIDTH-1:0] conflict,
    output logic             conflict_seen
`endif
);

    typedef enum logic [1:0] {
        BOTH_HOLD   = 2'd0,
        BOTH_SET    = 2'd1,
        BOTH_RST    = 2'd2,
        BOTH_TOGGLE = 2'd3
    } both_mode_e;

    // Out-of-range BOTH_MODE values fall back to hold.
    localparam both_mode_e MODE = (BOTH_MODE == 32'd1) ? BOTH_SET    :
                                  (BOTH_MODE == 32'd2) ? BOTH_RST    :
                                  (BOTH_MODE == 32'd3) ? BOTH_TOGGLE :
                                                         BOTH_HOLD;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            case ({s[i], r[i]})
                2'b10:   q_d[i] = 1'b1;
                2'b01:   q_d[i] = 1'b0;
                2'b11: begin
                    case (MODE)
                        BOTH_SET:    q_d[i] = 1'b1;
                        BOTH_RST:    q_d[i] = 1'b0;
                        BOTH_TOGGLE: q_d[i] = ~q_q[i];
                        default:     q_d[i] = q_q[i];
                    endcase
                end
                default: q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

`ifdef SRFF_CONFLICT_FLAG_EN
    logic [WIDTH-1:0] conflict_q;
    logic [WIDTH-1:0] conflict_d;
    logic             seen_q;
    logic             seen_d;

    // The sticky flag rises on the same edge as the per-bit pulse it records.
    always_comb begin
        conflict_d = s & r;
        seen_d     = seen_q | (|conflict_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_q <= '0;
            seen_q     <= 1'b0;
        end else begin
            conflict_q <= conflict_d;
            seen_q     <= seen_d;
        end
    end

    assign conflict      = conflict_q;
    assign conflict_seen = seen_q;
`endif

endmodule

// File: tb/tb_sr_ff.sv
// Scoreboard bench for sr_ff: five 1-bit instances (BOTH_MODE 0,1,2,3 and illegal 5)
// plus a 4-bit instance with RESET_VAL=1010; a negedge monitor checks queued expectations.
module tb_sr_ff;

    logic       clk;
    logic       rst;
    logic       s1, r1;
    logic [3:0] s4, r4;
    logic [4:0] q1, qn1;
    logic [3:0] q4, qn4;
`ifdef SRFF_CONFLICT_FLAG_EN
    logic [4:0] cf1;
    logic [4:0] seen1;
    logic [3:0] cf4;
    logic       seen4;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [4:0] q1;
        logic [3:0] q4;
        logic [3:0] cf;
        logic       seen;
    } exp_t;

    exp_t sb[$];

    for (genvar k = 0; k < 5; k++) begin : g_mode
        sr_ff #(
            .WIDTH    (1),
            .BOTH_MODE((k == 4) ? 5 : k),
            .RESET_VAL(1'b0)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .s            (s1),
            .r            (r1),
            .q            (q1[k]),
            .qn           (qn1[k])
`ifdef SRFF_CONFLICT_FLAG_EN
            ,
            .conflict     (cf1[k]),
            .conflict_seen(seen1[k])
`endif
        );
    end

    sr_ff #(
        .WIDTH    (4),
        .BOTH_MODE(0),
        .RESET_VAL(4'b1010)
    ) u_dut4 (
        .clk          (clk),
        .rst          (rst),
        .s            (s4),
        .r            (r4),
        .q            (q4),
        .qn           (qn4)
`ifdef SRFF_CONFLICT_FLAG_EN
        ,
        .conflict     (cf4),
        .conflict_seen(seen4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [4:0] act, input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                cmp({e.tag, ".q1"},  q1,  e.q1);
                cmp({e.tag, ".qn1"}, qn1, ~e.q1);
                cmp({e.tag, ".q4"},  {1'b0, q4},  {1'b0, e.q4});
                cmp({e.tag, ".qn4"}, {1'b0, qn4}, {1'b0, ~e.q4});
`ifdef SRFF_CONFLICT_FLAG_EN
                cmp({e.tag, ".cf4"},   {1'b0, cf4}, {1'b0, e.cf});
                cmp({e.tag, ".seen4"}, {4'b0, seen4}, {4'b0, e.seen});
`endif
            end
        end
    end

    task automatic expect_out(input string tag, input logic [4:0] eq1, input logic [3:0] eq4,
                              input logic [3:0] ecf, input logic eseen);
        exp_t e;
        e.tag  = tag;
        e.q1   = eq1;
        e.q4   = eq4;
        e.cf   = ecf;
        e.seen = eseen;
        sb.push_back(e);
    endtask

    // Waits for the edge that samples the previous inputs, then drives new ones.
    task automatic apply(input logic ns1, input logic nr1, input logic [3:0] ns4, input logic [3:0] nr4);
        @(posedge clk);
        #1;
        s1 = ns1;
        r1 = nr1;
        s4 = ns4;
        r4 = nr4;
    endtask

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        s1  = 1'b1;
        r1  = 1'b0;
        s4  = 4'b1111;
        r4  = 4'b0000;

        // Reset held with set requests active.
        repeat (3) begin
            @(posedge clk);
            #1;
            expect_out("reset_hold", 5'b00000, 4'b1010, 4'b0000, 1'b0);
        end

        @(posedge clk);
        #3;
        rst = 1'b1;
        s4  = 4'b0000;
        expect_out("rel_pre", 5'b00000, 4'b1010, 4'b0000, 1'b0);

        apply(1'b1, 1'b0, 4'b0101, 4'b1000);
        expect_out("first_set", 5'b11111, 4'b1010, 4'b0000, 1'b0);

        apply(1'b0, 1'b1, 4'b0000, 4'b0011);
        expect_out("w4_setrst", 5'b11111, 4'b0111, 4'b0000, 1'b0);

        apply(1'b0, 1'b0, 4'b0000, 4'b0000);
        expect_out("clear", 5'b00000, 4'b0100, 4'b0000, 1'b0);

        apply(1'b1, 1'b0, 4'b0000, 4'b0000);
        expect_out("hold", 5'b00000, 4'b0100, 4'b0000, 1'b0);

        apply(1'b1, 1'b1, 4'b0001, 4'b0001);
        expect_out("set_again", 5'b11111, 4'b0100, 4'b0000, 1'b0);

        apply(1'b1, 1'b1, 4'b0000, 4'b0000);
        expect_out("both_1", 5'b10011, 4'b0100, 4'b0001, 1'b1);

        apply(1'b1, 1'b0, 4'b0000, 4'b0000);
        expect_out("both_2", 5'b11011, 4'b0100, 4'b0000, 1'b1);

        apply(1'b0, 1'b0, 4'b0000, 4'b0000);
        expect_out("set_after", 5'b11111, 4'b0100, 4'b0000, 1'b1);

        // Reset pulled between edges must act before the next rising edge.
        @(posedge clk);
        #3;
        rst = 1'b0;
        s1  = 1'b1;
        s4  = 4'b0101;
        expect_out("async_rst", 5'b00000, 4'b1010, 4'b0000, 1'b0);

        repeat (3) begin
            @(posedge clk);
            #1;
            expect_out("rst_s_hold", 5'b00000, 4'b1010, 4'b0000, 1'b0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain actual=%0d required=0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
